// File: rtl/sync_edge_filter.sv
// sync_edge_filter: debounces a synchronized level, emits edge pulses, buffers one edge event, counts edges.
//   rd_clk     - sole clock, rising edge
//   rd_reset   - asynchronous active-low reset
//   sync_in    - level already synchronized into rd_clk
//   evt_ready  - downstream accepts the buffered event
//   clr_in     - synchronous clear of evt_count and evt_drop
//   filt_level - debounced level
//   rise_pulse - one-cycle pulse on a qualified 0->1
//   fall_pulse - one-cycle pulse on a qualified 1->0
//   evt_valid  - buffer holds an unconsumed event
//   evt_rise   - buffered event type (1 = rise), meaningful with evt_valid
//   evt_count  - saturating count of qualified edges
//   evt_drop   - sticky: an event was lost to a full buffer
module sync_edge_filter #(
   parameter int STABLE_CYCLES = 3,
   parameter int CNT_W         = 8
) (
   input  logic             rd_clk,
   input  logic             rd_reset,
   input  logic             sync_in,
   input  logic             evt_ready,
   input  logic             clr_in,
   output logic             filt_level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             evt_valid,
   output logic             evt_rise,
   output logic [CNT_W-1:0] evt_count,
   output logic             evt_drop
);
   typedef enum logic [1:0] {LOW, RISE_QUAL, HIGH, FALL_QUAL} state_t;
   localparam logic [3:0] Q_LAST = 4'(STABLE_CYCLES - 1);
   state_t           r_state, w_state_nxt;
   logic [3:0]       r_q_cnt, w_q_nxt;
   logic             w_rise, w_fall, w_evt, w_load, w_lost;
   logic             r_rise, r_fall, r_evt_valid, r_evt_rise, r_drop;
   logic [CNT_W-1:0] r_count;
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      case (r_state)
         LOW:
            if (sync_in) begin
               if (STABLE_CYCLES == 1) begin
                  w_state_nxt = HIGH;
                  w_rise      = 1'b1;
               end else begin
                  w_state_nxt = RISE_QUAL;
                  w_q_nxt     = 4'd1;
               end
            end
         RISE_QUAL:
            if (!sync_in) begin
               w_state_nxt = LOW;
               w_q_nxt     = 4'd0;
            end else if (r_q_cnt == Q_LAST) begin
               w_state_nxt = HIGH;
               w_q_nxt     = 4'd0;
               w_rise      = 1'b1;
            end else
               w_q_nxt = r_q_cnt + 4'd1;
         HIGH:
            if (!sync_in) begin
               if (STABLE_CYCLES == 1) begin
                  w_state_nxt = LOW;
                  w_fall      = 1'b1;
               end else begin
                  w_state_nxt = FALL_QUAL;
                  w_q_nxt     = 4'd1;
               end
            end
         FALL_QUAL:
            if (sync_in) begin
               w_state_nxt = HIGH;
               w_q_nxt     = 4'd0;
            end else if (r_q_cnt == Q_LAST) begin
               w_state_nxt = LOW;
               w_q_nxt     = 4'd0;
               w_fall      = 1'b1;
            end else
               w_q_nxt = r_q_cnt + 4'd1;
      endcase
   end
   // A pop in the same cycle frees the slot, so the new event still loads.
   assign w_evt  = w_rise | w_fall;
   assign w_load = w_evt & (~r_evt_valid | evt_ready);
   assign w_lost = w_evt & r_evt_valid & ~evt_ready;
   always_ff @(posedge rd_clk or negedge rd_reset) begin
      if (!rd_reset) begin
         r_state     <= LOW;
         r_q_cnt     <= 4'd0;
         r_rise      <= 1'b0;
         r_fall      <= 1'b0;
         r_evt_valid <= 1'b0;
         r_evt_rise  <= 1'b0;
         r_count     <= '0;
         r_drop      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_q_cnt     <= w_q_nxt;
         r_rise      <= w_rise;
         r_fall      <= w_fall;
         r_evt_valid <= w_load | (r_evt_valid & ~evt_ready);
         r_evt_rise  <= w_load ? w_rise : r_evt_rise;
         r_count     <= clr_in ? '0 : (w_evt && r_count != '1) ? r_count + 1'b1 : r_count;
         r_drop      <= clr_in ? 1'b0 : r_drop | w_lost;
      end
   end
   assign filt_level = (r_state == HIGH) || (r_state == FALL_QUAL);
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;
   assign evt_valid  = r_evt_valid;
   assign evt_rise   = r_evt_rise;
   assign evt_count  = r_count;
   assign evt_drop   = r_drop;
endmodule
